cr_cddip_pipe_watchdog: RTL and testbench
=========================================

// Module: cr_cddip_pipe_watchdog
// PURPOSE
//  Hang detector downstream of the support core. Consumes its pipe_stat command counts and the
//  ISF/OSF CQE-exit progress pulses. Times how long the pipe stays busy without completing a
//  command; on timeout raises a sticky interrupt and a halt request toward OSF. Logs hang events.
// PARAMETERS
//  TMR_W    24   width of stall timer and wdog_timeout
//  HANG_W   8    width of saturating hang event counter
// PORTS
//  clk            in   1       clock
//  rst            in   1       async reset, active-high
//  pipe_cmds      in   8       commands in pipe (pipe_stat.pipe_cmds)
//  isf_cmds       in   8       commands in ISF (pipe_stat.isf_cmds)
//  osf_cqe_exit   in   1       progress pulse: CQE left OSF
//  isf_cqe_exit   in   1       progress pulse: CQE left ISF
//  wdog_en        in   1       level enable, from register
//  wdog_timeout   in   TMR_W   stall cycles allowed; 0 = watchdog disabled
//  irq_clr        in   1       single-cycle W1C pulse from register block
//  wdog_irq       out  1       sticky hang interrupt
//  wdog_halt      out  1       halt request to OSF
//  wdog_state     out  2       FSM state: 0 IDLE, 1 ARMED, 2 EXPIRED
//  stall_timer    out  TMR_W   live stall count
//  hang_cnt       out  HANG_W  saturating count of expiries
//  snap_pipe_cmds out  8       pipe_cmds captured at expiry (optional feature)
//  snap_isf_cmds  out  8       isf_cmds captured at expiry (optional feature)
// BEHAVIOUR
//  - Reset: state IDLE. stall_timer=0, hang_cnt=0, snapshots=0, wdog_irq=0, wdog_halt=0.
//  - All outputs are registered. progress = osf_cqe_exit | isf_cqe_exit. active = wdog_en & (wdog_timeout!=0).
//  - IDLE: stall_timer held at 0.
//    - Goes to ARMED when active & (pipe_cmds!=0).
//  - ARMED: stall_timer is cleared to 0 on any cycle with progress; otherwise it increments by 1.
//    - Goes to IDLE, timer cleared, when !active or pipe_cmds==0.
//    - Goes to EXPIRED when !progress & (stall_timer+1 >= wdog_timeout).
//    - Timing: wdog_irq rises exactly wdog_timeout cycles after the last progress or arming cycle.
//    - Progress in the compare cycle wins: no expiry, timer cleared.
//    - The compare uses the live wdog_timeout. If wdog_timeout is lowered below stall_timer,
//      the block expires on the next cycle.
//  - Entering EXPIRED sets wdog_irq=1 and wdog_halt=1, and increments hang_cnt.
//    - hang_cnt saturates at 2^HANG_W-1 and does not wrap.
//  - EXPIRED: stall_timer frozen. Progress pulses are ignored, so the interrupt stays sticky.
//    - On irq_clr: wdog_irq=0 and wdog_halt=0. Next state is ARMED with timer 0 if
//      pipe_cmds!=0 & active, else IDLE.
//    - On !wdog_en: IDLE, irq and halt cleared, hang_cnt kept.
//  - irq_clr has no effect outside EXPIRED. irq_clr in the same cycle as an expiry compare
//    does not prevent the expiry.
//  - Precedence within a cycle: rst > !active > irq_clr (EXPIRED only) > progress > count/compare.
//  - Async reset mid-count or mid-EXPIRED returns everything to reset values immediately.
// CONFIGURATION
//  - Macro CR_CDDIP_WDOG_SNAPSHOT_EN defined: on the EXPIRED-entry edge, snap_pipe_cmds and
//    snap_isf_cmds capture pipe_cmds and isf_cmds.
//    - Snapshots hold until the next expiry or reset. irq_clr does not clear them.
//  - Macro undefined: snap_* are tied to 8'h0 and no capture flops are built.
// TESTING
//  1. Reset, then timeout=16, en=1, pipe_cmds=3, no progress.
//     -> ARMED next cycle; irq and halt rise 16 cycles later; hang_cnt=1.
//  2. As 1, but an osf_cqe_exit pulse every 10 cycles.
//     -> No expiry; stall_timer never exceeds 9.
//  3. Progress pulse on the compare cycle (stall_timer=15, timeout=16).
//     -> No expiry; timer=0 next cycle.
//  4. In EXPIRED: progress pulses keep irq=1. irq_clr with pipe_cmds=2 -> ARMED, timer 0.
//     irq_clr with pipe_cmds=0 -> IDLE.
//  5. 260 back-to-back expiries with HANG_W=8.
//     -> hang_cnt holds 255. wdog_en=0 in EXPIRED -> IDLE, irq=0, hang_cnt=255.
//  6. SNAPSHOT_EN: expiry with pipe_cmds=5, isf_cmds=2.
//     -> snap values 5/2, held after irq_clr. Without the macro, snap_* stay 0.

Source files
------------

// File: rtl/cr_cddip_pipe_watchdog.sv
// Pipe hang watchdog: times busy-without-progress stalls, raises a sticky irq/halt and counts hangs.
// Define CR_CDDIP_WDOG_SNAPSHOT_EN to capture pipe_cmds/isf_cmds on each expiry.
module cr_cddip_pipe_watchdog #(
    parameter int TMR_W  = 24,
    parameter int HANG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        pipe_cmds,
    input  logic [7:0]        isf_cmds,
    input  logic              osf_cqe_exit,
    input  logic              isf_cqe_exit,
    input  logic              wdog_en,
    input  logic [TMR_W-1:0]  wdog_timeout,
    input  logic              irq_clr,
    output logic              wdog_irq,
    output logic              wdog_halt,
    output logic [1:0]        wdog_state,
    output logic [TMR_W-1:0]  stall_timer,
    output logic [HANG_W-1:0] hang_cnt,
    output logic [7:0]        snap_pipe_cmds,
    output logic [7:0]        snap_isf_cmds
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } wdog_state_e;

    wdog_state_e      state;
    logic             progress;
    logic             active;
    logic             cmds_busy;
    logic             stall_hit;
    logic             expire_evt;
    logic [TMR_W:0]   timer_inc;

    function automatic logic [HANG_W-1:0] sat_inc(input logic [HANG_W-1:0] v);
        return (&v) ? v : v + {{(HANG_W-1){1'b0}}, 1'b1};
    endfunction

    assign progress   = osf_cqe_exit | isf_cqe_exit;
    assign active     = wdog_en & (wdog_timeout != '0);
    assign cmds_busy  = (pipe_cmds != 8'h0);
    // One extra bit so a timer at all-ones cannot wrap past the live timeout.
    assign timer_inc  = {1'b0, stall_timer} + {{TMR_W{1'b0}}, 1'b1};
    assign stall_hit  = (timer_inc >= {1'b0, wdog_timeout});
    assign expire_evt = (state == ARMED) & active & cmds_busy & ~progress & stall_hit;
    assign wdog_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            stall_timer <= '0;
            hang_cnt    <= '0;
            wdog_irq    <= 1'b0;
            wdog_halt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stall_timer <= '0;
                    if (active && cmds_busy) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (!active || !cmds_busy) begin
                        state       <= IDLE;
                        stall_timer <= '0;
                    end else if (progress) begin
                        stall_timer <= '0;
                    end else if (stall_hit) begin
                        state     <= EXPIRED;
                        wdog_irq  <= 1'b1;
                        wdog_halt <= 1'b1;
                        hang_cnt  <= sat_inc(hang_cnt);
                    end else begin
                        stall_timer <= timer_inc[TMR_W-1:0];
                    end
                end
                EXPIRED: begin
                    // Timer stays frozen and progress is ignored until software or disable releases it.
                    if (!active) begin
                        state       <= IDLE;
                        stall_timer <= '0;
                        wdog_irq    <= 1'b0;
                        wdog_halt   <= 1'b0;
                    end else if (irq_clr) begin
                        state       <= cmds_busy ? ARMED : IDLE;
                        stall_timer <= '0;
                        wdog_irq    <= 1'b0;
                        wdog_halt   <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    stall_timer <= '0;
                end
            endcase
        end
    end

`ifdef CR_CDDIP_WDOG_SNAPSHOT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_pipe_cmds <= 8'h0;
            snap_isf_cmds  <= 8'h0;
        end else if (expire_evt) begin
            snap_pipe_cmds <= pipe_cmds;
            snap_isf_cmds  <= isf_cmds;
        end
    end
`else
    logic snap_unused;
    assign snap_unused    = ^{isf_cmds, expire_evt};
    assign snap_pipe_cmds = 8'h0;
    assign snap_isf_cmds  = 8'h0;
`endif

endmodule

// File: tb/tb_cr_cddip_pipe_watchdog.sv
// Table-driven, scoreboarded bench for cr_cddip_pipe_watchdog (TMR_W=24, HANG_W=8).
module tb_cr_cddip_pipe_watchdog;

    localparam int TMR_W  = 24;
    localparam int HANG_W = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_EXP  = 2'd2;
`ifdef CR_CDDIP_WDOG_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        pipe_cmds;
    logic [7:0]        isf_cmds;
    logic              osf_cqe_exit;
    logic              isf_cqe_exit;
    logic              wdog_en;
    logic [TMR_W-1:0]  wdog_timeout;
    logic              irq_clr;
    logic              wdog_irq;
    logic              wdog_halt;
    logic [1:0]        wdog_state;
    logic [TMR_W-1:0]  stall_timer;
    logic [HANG_W-1:0] hang_cnt;
    logic [7:0]        snap_pipe_cmds;
    logic [7:0]        snap_isf_cmds;

    cr_cddip_pipe_watchdog #(.TMR_W(TMR_W), .HANG_W(HANG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_cmds      (pipe_cmds),
        .isf_cmds       (isf_cmds),
        .osf_cqe_exit   (osf_cqe_exit),
        .isf_cqe_exit   (isf_cqe_exit),
        .wdog_en        (wdog_en),
        .wdog_timeout   (wdog_timeout),
        .irq_clr        (irq_clr),
        .wdog_irq       (wdog_irq),
        .wdog_halt      (wdog_halt),
        .wdog_state     (wdog_state),
        .stall_timer    (stall_timer),
        .hang_cnt       (hang_cnt),
        .snap_pipe_cmds (snap_pipe_cmds),
        .snap_isf_cmds  (snap_isf_cmds)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]        pipe;
        logic [7:0]        isf;
        logic              osf_x;
        logic              isf_x;
        logic              clr;
        logic              en;
        logic [TMR_W-1:0]  tmo;
        logic [1:0]        st;
        logic [TMR_W-1:0]  tmr;
        logic              irq;
        logic [HANG_W-1:0] hang;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   hang_e = 0;

    function automatic vec_t V(input logic [7:0] pipe, input logic [7:0] isf, input logic osf_x,
                               input logic isf_x, input logic clr, input logic en,
                               input logic [TMR_W-1:0] tmo, input logic [1:0] st,
                               input logic [TMR_W-1:0] tmr, input logic irq, input int hang);
        vec_t v;
        v.pipe = pipe; v.isf = isf; v.osf_x = osf_x; v.isf_x = isf_x; v.clr = clr; v.en = en;
        v.tmo = tmo; v.st = st; v.tmr = tmr; v.irq = irq; v.hang = hang[HANG_W-1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expected post-edge outputs, compare after the edge.
    task automatic step(input string name, input vec_t v);
        vec_t e;
        pipe_cmds    = v.pipe;
        isf_cmds     = v.isf;
        osf_cqe_exit = v.osf_x;
        isf_cqe_exit = v.isf_x;
        irq_clr      = v.clr;
        wdog_en      = v.en;
        wdog_timeout = v.tmo;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({name, ".state"}, {30'd0, wdog_state}, {30'd0, e.st});
        chk({name, ".timer"}, {8'd0, stall_timer}, {8'd0, e.tmr});
        chk({name, ".irq"},   {31'd0, wdog_irq},   {31'd0, e.irq});
        chk({name, ".halt"},  {31'd0, wdog_halt},  {31'd0, e.irq});
        chk({name, ".hang"},  {24'd0, hang_cnt},   {24'd0, e.hang});
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, ".state"}, {30'd0, wdog_state}, 32'd0);
        chk({name, ".timer"}, {8'd0, stall_timer}, 32'd0);
        chk({name, ".irq"},   {31'd0, wdog_irq},   32'd0);
        chk({name, ".halt"},  {31'd0, wdog_halt},  32'd0);
        chk({name, ".hang"},  {24'd0, hang_cnt},   32'd0);
        chk({name, ".snap_pipe"}, {24'd0, snap_pipe_cmds}, 32'd0);
        chk({name, ".snap_isf"},  {24'd0, snap_isf_cmds},  32'd0);
    endtask

    initial begin
        rst = 1'b1;
        pipe_cmds = 8'd0; isf_cmds = 8'd0; osf_cqe_exit = 1'b0; isf_cqe_exit = 1'b0;
        wdog_en = 1'b0; wdog_timeout = '0; irq_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        // Arm, run to expiry, sticky under progress, clear back to ARMED, progress on the compare cycle.
        tbl.push_back(V(3, 0, 0, 0, 0, 1, 16, S_ARM, 0, 0, 0));
        for (int k = 1; k <= 15; k++) tbl.push_back(V(3, 0, 0, 0, 0, 1, 16, S_ARM, k, 0, 0));
        tbl.push_back(V(3, 0, 0, 0, 0, 1, 16, S_EXP, 15, 1, 1));
        tbl.push_back(V(3, 0, 1, 0, 0, 1, 16, S_EXP, 15, 1, 1));
        tbl.push_back(V(3, 0, 0, 1, 0, 1, 16, S_EXP, 15, 1, 1));
        tbl.push_back(V(2, 0, 0, 0, 1, 1, 16, S_ARM, 0, 0, 1));
        for (int k = 1; k <= 15; k++) tbl.push_back(V(2, 0, 0, 0, 0, 1, 16, S_ARM, k, 0, 1));
        tbl.push_back(V(2, 0, 0, 1, 0, 1, 16, S_ARM, 0, 0, 1));
        foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);
        hang_e = 1;

        // Progress every 10 cycles keeps the timer at or below 9.
        for (int j = 1; j <= 60; j++)
            step($sformatf("periodic%0d", j),
                 V(3, 0, (j % 10 == 0), 0, 0, 1, 16, S_ARM, j % 10, 0, hang_e));

        // irq_clr ignored in ARMED; lowering timeout below the timer expires on the next edge.
        step("clr_armed", V(3, 0, 0, 0, 1, 1, 16, S_ARM, 1, 0, hang_e));
        for (int k = 2; k <= 10; k++) step("count", V(3, 0, 0, 0, 0, 1, 16, S_ARM, k, 0, hang_e));
        hang_e++;
        step("tmo_lowered", V(3, 0, 0, 0, 0, 1, 5, S_EXP, 10, 1, hang_e));
        step("disable_exp", V(3, 0, 0, 0, 0, 0, 5, S_IDLE, 0, 0, hang_e));

        // Inactive conditions keep IDLE; clr coincident with expiry compare still expires.
        step("idle_en0",   V(3, 0, 0, 0, 0, 0, 4, S_IDLE, 0, 0, hang_e));
        step("idle_tmo0",  V(3, 0, 0, 0, 0, 1, 0, S_IDLE, 0, 0, hang_e));
        step("idle_pipe0", V(0, 0, 0, 0, 0, 1, 4, S_IDLE, 0, 0, hang_e));
        step("arm4",       V(3, 0, 0, 0, 0, 1, 4, S_ARM, 0, 0, hang_e));
        for (int k = 1; k <= 3; k++) step("count4", V(3, 0, 0, 0, 0, 1, 4, S_ARM, k, 0, hang_e));
        hang_e++;
        step("clr_at_cmp", V(3, 0, 0, 0, 1, 1, 4, S_EXP, 3, 1, hang_e));
        step("clr_pipe0",  V(0, 0, 0, 0, 1, 1, 4, S_IDLE, 0, 0, hang_e));
        step("arm_b",      V(1, 0, 0, 0, 0, 1, 4, S_ARM, 0, 0, hang_e));
        step("count_b",    V(1, 0, 0, 0, 0, 1, 4, S_ARM, 1, 0, hang_e));
        step("tmo0_armed", V(1, 0, 0, 0, 0, 1, 0, S_IDLE, 0, 0, hang_e));
        step("arm_c",      V(1, 0, 0, 0, 0, 1, 4, S_ARM, 0, 0, hang_e));
        step("pipe0_armd", V(0, 0, 0, 0, 0, 1, 4, S_IDLE, 0, 0, hang_e));

        // Snapshot capture on expiry, held through irq_clr and changing inputs.
        step("snap_arm", V(5, 2, 0, 0, 0, 1, 3, S_ARM, 0, 0, hang_e));
        step("snap_c1",  V(5, 2, 0, 0, 0, 1, 3, S_ARM, 1, 0, hang_e));
        step("snap_c2",  V(5, 2, 0, 0, 0, 1, 3, S_ARM, 2, 0, hang_e));
        hang_e++;
        step("snap_exp", V(5, 2, 0, 0, 0, 1, 3, S_EXP, 2, 1, hang_e));
        chk("snap_pipe", {24'd0, snap_pipe_cmds}, SNAP ? 32'd5 : 32'd0);
        chk("snap_isf",  {24'd0, snap_isf_cmds},  SNAP ? 32'd2 : 32'd0);
        step("snap_clr", V(6, 7, 0, 0, 1, 1, 3, S_ARM, 0, 0, hang_e));
        step("snap_run", V(6, 7, 0, 0, 0, 1, 3, S_ARM, 1, 0, hang_e));
        chk("snap_pipe_held", {24'd0, snap_pipe_cmds}, SNAP ? 32'd5 : 32'd0);
        chk("snap_isf_held",  {24'd0, snap_isf_cmds},  SNAP ? 32'd2 : 32'd0);
        step("snap_off", V(6, 7, 0, 0, 0, 0, 3, S_IDLE, 0, 0, hang_e));

        // 260 back-to-back expiries: hang_cnt saturates at 255.
        step("sat_arm", V(1, 0, 0, 0, 0, 1, 1, S_ARM, 0, 0, hang_e));
        for (int i = 0; i < 260; i++) begin
            hang_e = (hang_e >= 255) ? 255 : hang_e + 1;
            step($sformatf("sat_exp%0d", i), V(1, 0, 0, 0, 0, 1, 1, S_EXP, 0, 1, hang_e));
            if (i != 259)
                step($sformatf("sat_clr%0d", i), V(1, 0, 0, 0, 1, 1, 1, S_ARM, 0, 0, hang_e));
        end
        step("sat_disable", V(1, 0, 0, 0, 0, 0, 1, S_IDLE, 0, 0, 255));

        // Asynchronous reset mid-count.
        step("rc_arm", V(1, 0, 0, 0, 0, 1, 100, S_ARM, 0, 0, 255));
        for (int k = 1; k <= 5; k++) step("rc_count", V(1, 0, 0, 0, 0, 1, 100, S_ARM, k, 0, 255));
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst_count");
        @(posedge clk);
        #1 rst = 1'b0;

        // Asynchronous reset mid-EXPIRED, after a snapshot capture.
        step("re_arm", V(9, 4, 0, 0, 0, 1, 2, S_ARM, 0, 0, 0));
        step("re_c1",  V(9, 4, 0, 0, 0, 1, 2, S_ARM, 1, 0, 0));
        step("re_exp", V(9, 4, 0, 0, 0, 1, 2, S_EXP, 1, 1, 1));
        chk("re_snap_pipe", {24'd0, snap_pipe_cmds}, SNAP ? 32'd9 : 32'd0);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst_exp");
        @(posedge clk);
        #1 rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
